mod_addsub_pipe: RTL and testbench
==================================

Name: mod_addsub_pipe

Overview:
Pipelined, parametrised modular add/subtract unit for the Kyber/NTT datapath. It computes (a + b) mod Q or (a − b) mod Q, selected per transaction. A valid/ready handshake with full backpressure lets it sit between the coefficient memory read port and the butterfly/write-back stages. It supersedes the single-cycle combinational adder: Q and W are parameters, subtraction is added, and there is a range-error flag and a tag passthrough.

Parameters:
W, 12, coefficient width in bits
Q, 3329, modulus; elaboration error unless 1 < Q < 2**W
TAG_W, 4, width of the opaque tag carried alongside each operation

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input transaction valid
in_ready  out  1  unit can accept an input this cycle
in_op  in  1  0 = add, 1 = subtract
in_a  in  W  operand a, expected in [0, Q-1]
in_b  in  W  operand b, expected in [0, Q-1]
in_tag  in  TAG_W  opaque tag, returned unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_result  out  W  reduced result
out_tag  out  TAG_W  tag of this result
out_range_err  out  1  a or b was >= Q on input

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high. While rst is high, both stage valids clear, so out_valid = 0 and in_ready = 1 in the reset-exit cycle. out_result, out_tag and out_range_err reset to 0.
- Two register stages, S1 and S2. S2 drives the outputs directly, so there is no combinational path from inputs to outputs.
- S1 captures on in_valid && in_ready:
  - raw = a + b (add) or a − b (sub), computed at W+1 bits (two's complement for sub);
  - op;
  - tag;
  - err = (a >= Q) || (b >= Q).
- S2 performs the correction:
  - add: result = (raw >= Q) ? raw − Q : raw;
  - sub: result = raw[W] (borrow) ? raw + Q : raw;
  - the result is truncated to W bits.
  - For in-range operands the result is always in [0, Q-1].
  - For out-of-range operands the same formula is applied without guarantee, and out_range_err = 1.
- Advance rules:
  - S2 loads when !S2.valid || out_ready.
  - S1 loads when !S1.valid || S2 loads.
  - in_ready = !S1.valid || S2 loads. This is combinational from out_ready; accept the path.
- Latency: 2 cycles from accept to out_valid when unstalled. Throughput: 1 operation per cycle. Capacity: 2 in-flight operations.
- Stall: while out_valid && !out_ready, all out_* signals hold stable. No transaction is ever dropped or duplicated.
- Simultaneous accept at the input and pop at the output in the same cycle must sustain full rate.
- Ordering: strictly in order; tags are not interpreted.
- Reset asserted mid-operation discards all in-flight data.

Decomposition:
- Shared package ntt_pkg holds:
  - KYBER_Q = 3329 and COEF_W = 12, used as the parameter defaults;
  - typedef enum logic {OP_ADD, OP_SUB} modop_e.
- One natural sub-module, mod_correct: the combinational S2 correction (raw, op → result). It is reusable by the butterfly unit.
- The two pipeline stages stay in the top module.

Test Plan:
1. Basic add: add a=3000, b=1000 with out_ready=1. Expect result=671 exactly 2 cycles after accept, err=0.
2. Add and subtract boundaries:
   - add 3328 + 3328 → 3327;
   - sub 5 − 10 → 3324;
   - sub 0 − 3328 → 1;
   - sub 7 − 7 → 0;
   - add 0 + 0 → 0.
3. Backpressure: hold out_ready=0 and offer tags 1, 2, 3 back-to-back. Expect:
   - tags 1 and 2 accepted, then in_ready=0;
   - out_* held stable on tag 1;
   - on release, tags 1, 2, 3 emerge in order, one per cycle.
4. Streaming: 1000 random in-range operations with random out_ready toggling. Results match the reference model, and there is no loss, duplication or reorder.
5. Range error: add a=3329, b=0. Expect out_range_err=1, with the tag returned intact.
6. Reset mid-operation: assert rst asynchronously (between clock edges) with 2 operations in flight. Expect:
   - out_valid drops immediately, in_ready=1 after reset exit;
   - no stale result appears afterwards;
   - a following add 1 + 1 → 2.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types and constants for the Kyber/NTT coefficient datapath.
package ntt_pkg;

  localparam int unsigned KYBER_Q = 3329;
  localparam int unsigned COEF_W  = 12;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } modop_e;

endpackage

// File: rtl/mod_correct.sv
// Final modular correction of a W+1-bit raw add/sub value into [0, Q-1].
// Reused by the butterfly unit, so it stays purely combinational.
module mod_correct
  import ntt_pkg::*;
#(
  parameter int unsigned W = COEF_W,
  parameter int unsigned Q = KYBER_Q
) (
  input  logic [W:0]   raw,
  input  modop_e       op,
  output logic [W-1:0] result_c
);

  localparam logic [W:0] QX = (W+1)'(Q);

  // Add overflows past Q at most once; a sub borrow shows up in the top bit.
  always_comb begin
    result_c = W'(raw);
    if (op == OP_ADD) begin
      if (raw >= QX) result_c = W'(raw - QX);
    end else begin
      if (raw[W]) result_c = W'(raw + QX);
    end
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage modular add/subtract with valid/ready backpressure and tag passthrough.
// S1 forms the raw sum/difference, S2 corrects it and drives the outputs.
module mod_addsub_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned W     = COEF_W,
  parameter int unsigned Q     = KYBER_Q,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_range_err
);

  if (Q <= 1 || 64'(Q) >= (64'd1 << W)) begin : g_bad_q
    $error("mod_addsub_pipe: Q must satisfy 1 < Q < 2**W");
  end

  typedef struct packed {
    logic [W:0]     raw;
    modop_e         op;
    logic [TAG_W-1:0] tag;
    logic           err;
  } s1_t;

  logic         s1_valid;
  s1_t          s1_q;
  s1_t          s1_d_c;
  logic         s2_load_c;
  logic         s1_load_c;
  logic [W-1:0] corr_c;

  assign s2_load_c = !out_valid || out_ready;
  assign s1_load_c = !s1_valid || s2_load_c;
  assign in_ready  = s1_load_c;

  // Raw result at W+1 bits; subtraction wraps two's complement into the top bit.
  always_comb begin
    s1_d_c     = '0;
    s1_d_c.op  = modop_e'(in_op);
    s1_d_c.tag = in_tag;
    s1_d_c.err = (in_a >= W'(Q)) || (in_b >= W'(Q));
    if (in_op) s1_d_c.raw = {1'b0, in_a} - {1'b0, in_b};
    else       s1_d_c.raw = {1'b0, in_a} + {1'b0, in_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load_c) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d_c;
    end
  end

  mod_correct #(.W(W), .Q(Q)) u_corr (
    .raw      (s1_q.raw),
    .op       (s1_q.op),
    .result_c (corr_c)
  );

  // Output stage only updates on a load, so outputs hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_tag       <= '0;
      out_range_err <= 1'b0;
    end else if (s2_load_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result    <= corr_c;
        out_tag       <= s1_q.tag;
        out_range_err <= s1_q.err;
      end
    end
  end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Scoreboard bench for mod_addsub_pipe: expected results queued on accept, compared on output.
module tb_mod_addsub_pipe;

  localparam int unsigned W     = 12;
  localparam int unsigned Q     = 3329;
  localparam int unsigned TAG_W = 4;

  typedef struct {
    int res;
    int tag;
    int err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_range_err;

  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_ready = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mod_addsub_pipe #(.W(W), .Q(Q), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_tag        (in_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_tag       (out_tag),
    .out_range_err (out_range_err)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input bit op, input int a, input int b, input int tag);
    exp_t e;
    if (!op) e.res = (a + b) % Q;
    else     e.res = (((a - b) % int'(Q)) + int'(Q)) % int'(Q);
    e.tag = tag % (1 << TAG_W);
    e.err = (a >= int'(Q) || b >= int'(Q)) ? 1 : 0;
    return e;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic send(input bit op, input int a, input int b, input int tag);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = W'(a);
    in_b     = W'(b);
    in_tag   = TAG_W'(tag);
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(op, a, b, tag));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: every visible result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        check("result", 32'(out_result), 32'(sb[0].res));
        check("tag", 32'(out_tag), 32'(sb[0].tag));
        check("range_err", 32'(out_range_err), 32'(sb[0].err));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(out_result), 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    check("rst_err", 32'(out_range_err), 32'd0);
    #3 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic add with latency check.
    send(1'b0, 3000, 1000, 5);
    @(negedge clk);
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    check("lat_result", 32'(out_result), 32'd671);
    @(posedge clk);
    #1;
    drain();

    // Boundaries, back to back.
    send(1'b0, 3328, 3328, 1);
    send(1'b1, 5, 10, 2);
    send(1'b1, 0, 3328, 3);
    send(1'b1, 7, 7, 4);
    send(1'b0, 0, 0, 5);
    drain();

    // Backpressure: two slots fill, third waits until release.
    out_ready = 1'b0;
    send(1'b0, 10, 20, 1);
    send(1'b0, 11, 21, 2);
    fork
      send(1'b0, 12, 22, 3);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_hold_tag", 32'(out_tag), 32'd1);
          check("bp_hold_res", 32'(out_result), 32'd30);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
          @(negedge clk);
          check("bp_order_valid", 32'(out_valid), 32'd1);
          check("bp_order_tag", 32'(out_tag), 32'(k));
        end
      end
    join
    drain();

    // Random streaming with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(1'($urandom_range(0, 1)), int'($urandom_range(0, Q - 1)),
           int'($urandom_range(0, Q - 1)), i);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    drain();

    // Out-of-range operand.
    send(1'b0, 3329, 0, 9);
    drain();

    // Asynchronous reset with two operations in flight.
    out_ready = 1'b0;
    send(1'b0, 100, 200, 6);
    send(1'b1, 300, 100, 7);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(1'b0, 1, 1, 8);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
